// File: rtl/uart_fifo_sched_if.sv
// Bus bundle for uart_fifo_sched.
// Groups the producer handshakes, the FIFO write/read ports and the TX engine
// handshake so the scheduler exposes a single port besides clk/rst.
//   slave  : scheduler view (consumes requests and FIFO flags, drives strobes/TX)
//   master : environment view (producers, FIFO and transmitter)
interface uart_fifo_sched_if #(
  parameter int unsigned WORD = 8,
  parameter int unsigned CNTW = 16
);
  // Producer 0 / 1 write requests
  logic            req0_valid;
  logic [WORD-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [WORD-1:0] req1_data;
  logic            req1_ready;
  // FIFO ports
  logic            fifo_wr;
  logic [WORD-1:0] fifo_wr_data;
  logic            fifo_full;
  logic            fifo_rd;
  logic [WORD-1:0] fifo_rd_data;
  logic            fifo_empty;
  // Transmitter side
  logic            enable;
  logic            tx_start;
  logic [WORD-1:0] tx_data;
  logic            tx_busy;
  logic [CNTW-1:0] tx_count;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  fifo_full, fifo_rd_data, fifo_empty, enable, tx_busy,
    output req0_ready, req1_ready, fifo_wr, fifo_wr_data, fifo_rd,
    output tx_start, tx_data, tx_count
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output fifo_full, fifo_rd_data, fifo_empty, enable, tx_busy,
    input  req0_ready, req1_ready, fifo_wr, fifo_wr_data, fifo_rd,
    input  tx_start, tx_data, tx_count
  );
endinterface

// File: rtl/uart_fifo_sched.sv
// UART TX FIFO scheduler.
// Shares the FIFO write port between two producers with round-robin
// arbitration and drains the FIFO into the UART transmitter one word at a time
// using a start/busy handshake.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : uart_fifo_sched_if.slave (producer handshakes, FIFO ports, TX handshake)
module uart_fifo_sched #(
  parameter int unsigned WORD = 8,
  parameter int unsigned CNTW = 16
) (
  input logic              clk,
  input logic              rst,
  uart_fifo_sched_if.slave bus
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPop      = 3'd1;
  localparam logic [2:0] StLoad     = 3'd2;
  localparam logic [2:0] StWaitBusy = 3'd3;
  localparam logic [2:0] StWaitDone = 3'd4;

  // ---------------------------------------------------------------------------
  // Write arbiter
  // ---------------------------------------------------------------------------
  // last_q = 1 means producer 1 was granted most recently; reset value makes
  // producer 0 win the first tie.
  logic last_q, last_d;
  logic gnt0, gnt1;

  always_comb begin
    gnt0 = ~bus.fifo_full & bus.req0_valid & (~bus.req1_valid | last_q);
    gnt1 = ~bus.fifo_full & bus.req1_valid & (~bus.req0_valid | ~last_q);
  end

  always_comb begin
    last_d = last_q;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
    end
  end

  assign bus.req0_ready   = gnt0;
  assign bus.req1_ready   = gnt1;
  assign bus.fifo_wr      = gnt0 | gnt1;
  assign bus.fifo_wr_data = gnt1 ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  logic [2:0]      state_q, state_d;
  logic            tx_start_q, tx_start_d;
  logic [WORD-1:0] tx_data_q, tx_data_d;
  logic [CNTW-1:0] tx_count_q, tx_count_d;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_count_d = tx_count_q;
    // Pulse is exactly the cycle following LOAD.
    tx_start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.enable && !bus.fifo_empty && !bus.tx_busy) begin
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StLoad;
      end
      StLoad: begin
        // FIFO read data is valid the cycle after the pop strobe.
        tx_data_d  = bus.fifo_rd_data;
        tx_start_d = 1'b1;
        tx_count_d = tx_count_q + CNTW'(1);
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.tx_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_count_q <= tx_count_d;
    end
  end

  // Read strobe is a pure decode of the registered state, so it is 0 in reset.
  assign bus.fifo_rd  = (state_q == StPop);
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_count = tx_count_q;

endmodule
